alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_if.sv | 40 ++++
 rtl/alu_arb.sv | 101 ++++++++++
 tb/tb_alu_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// Bus bundle for alu_arb: two requester handshakes, their response strobes,
// and the shared-ALU operand/result signals.
interface alu_arb_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   req0_op;
    logic [2:0]   req1_op;
    logic         resp0_valid;
    logic         resp1_valid;
    logic [W-1:0] resp0_data;
    logic [W-1:0] resp1_data;
    logic [W-1:0] alu_src_a;
    logic [W-1:0] alu_src_b;
    logic [2:0]   alu_c;
    logic [W-1:0] alu_data_out;

    // Requesters plus the external ALU.
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, alu_data_out,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp0_data, resp1_data, alu_src_a, alu_src_b, alu_c
    );

    // The arbiter.
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, alu_data_out,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp0_data, resp1_data, alu_src_a, alu_src_b, alu_c
    );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU (IDLE->EXEC->RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arb #(
    parameter int W = 8
) (
    input logic     clk,
    input logic     rst,
    alu_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    logic         winner;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [2:0]   op_q;
    logic         resp0_valid_q;
    logic         resp1_valid_q;
    logic [W-1:0] resp0_data_q;
    logic [W-1:0] resp1_data_q;
    logic         gnt0;
    logic         gnt1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid & ~bus.req0_valid;
    end
`else
    // last_grant = 1 means req1 was served last, so req0 wins the next tie.
    logic last_grant;

    always_comb begin
        gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end
`endif

    assign bus.req0_ready  = ~rst & (state == IDLE) & gnt0;
    assign bus.req1_ready  = ~rst & (state == IDLE) & gnt1;
    assign bus.alu_src_a   = a_q;
    assign bus.alu_src_b   = b_q;
    assign bus.alu_c       = op_q;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp0_data  = resp0_data_q;
    assign bus.resp1_data  = resp1_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            winner        <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        winner <= gnt1;
                        a_q    <= gnt1 ? bus.req1_a  : bus.req0_a;
                        b_q    <= gnt1 ? bus.req1_b  : bus.req0_b;
                        op_q   <= gnt1 ? bus.req1_op : bus.req0_op;
                        state  <= EXEC;
                    end
                end
                // Result lands in the winner's data register together with its strobe.
                EXEC: begin
                    if (winner) begin
                        resp1_data_q  <= bus.alu_data_out;
                        resp1_valid_q <= 1'b1;
                    end else begin
                        resp0_data_q  <= bus.alu_data_out;
                        resp0_valid_q <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    resp0_valid_q <= 1'b0;
                    resp1_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant    <= winner;
`endif
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: vector table, scoreboard and directed corner cases.
module tb_alu_arb;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arb_if #(.W(W)) bus ();

    alu_arb #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            default: return a | b;
        endcase
    endfunction

    assign bus.alu_data_out = alu_ref(bus.alu_src_a, bus.alu_src_b, bus.alu_c);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   grants[$];

    // Scoreboard: expectations pushed on accept, popped on each response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("ready_in_rst", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
            sb.delete();
        end else begin
            if (bus.req0_ready | bus.req1_ready)
                check("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready) begin
                sb.push_back('{0, alu_ref(bus.req0_a, bus.req0_b, bus.req0_op)});
                grants.push_back(0);
            end else if (bus.req1_ready) begin
                sb.push_back('{1, alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)});
                grants.push_back(1);
            end
            if (bus.resp0_valid | bus.resp1_valid) begin
                check("resp_onehot", bus.resp0_valid & bus.resp1_valid, 0);
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", bus.resp0_valid | bus.resp1_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_id", bus.resp1_valid, e.id[0]);
                    check("sb_data", e.id[0] ? bus.resp1_data : bus.resp0_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic drive(input int id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] exp, input string name);
        logic seen;
        drive(id, 1'b1, a, b, op);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (id == 0) ? bus.req0_ready : bus.req1_ready;
        end
        check({name, "_accept"}, seen, 1);
        tick();
        drive(id, 1'b0, a, b, op);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (id == 0) ? bus.resp0_valid : bus.resp1_valid;
        end
        check({name, "_resp"}, seen, 1);
        if (seen)
            check({name, "_data"}, (id == 0) ? bus.resp0_data : bus.resp1_data, exp);
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 8'h55, 8'h1a, 3'b000, 8'h6f};
        vecs[1] = '{1, 8'h55, 8'h1a, 3'b001, 8'h3b};
        vecs[2] = '{0, 8'hff, 8'h01, 3'b000, 8'h00};
        vecs[3] = '{1, 8'h00, 8'h01, 3'b001, 8'hff};
        vecs[4] = '{0, 8'h80, 8'h80, 3'b000, 8'h00};
        vecs[5] = '{1, 8'hf0, 8'h3c, 3'b010, 8'h30};
        vecs[6] = '{0, 8'h7f, 8'h80, 3'b001, 8'hff};
        vecs[7] = '{1, 8'h00, 8'h00, 3'b000, 8'h00};

        rst = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);

        // Reset state
        do_reset();
        rst = 1'b1;
        drive(0, 1'b1, 8'h12, 8'h34, 3'b000);
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_resp", {30'd0, bus.resp1_valid, bus.resp0_valid}, 0);
        check("rst_data", {bus.resp1_data, bus.resp0_data}, 0);
        check("rst_alu", {bus.alu_c, bus.alu_src_a, bus.alu_src_b}, 0);

        // Single request: latency and operand change after accept
        do_reset();
        drive(0, 1'b1, 8'h55, 8'h1a, 3'b000);
        @(negedge clk);
        check("single_ready_T", bus.req0_ready, 1);
        tick();
        drive(0, 1'b0, 8'hff, 8'h1a, 3'b000);
        @(negedge clk);
        check("single_src_a_T1", bus.alu_src_a, 8'h55);
        check("single_no_resp_T1", bus.resp0_valid, 0);
        @(negedge clk);
        check("single_resp_T2", bus.resp0_valid, 1);
        check("single_data_T2", bus.resp0_data, 8'h6f);
        @(negedge clk);
        check("single_pulse_T3", bus.resp0_valid, 0);
        check("single_hold_T3", bus.resp0_data, 8'h6f);

        // Table of vectors
        for (int k = 0; k < 8; k++)
            run_op(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].exp,
                   $sformatf("vec%0d", k));
        repeat (2) @(negedge clk);
        check("hold_resp0", bus.resp0_data, 8'hff);
        check("hold_resp1", bus.resp1_data, 8'h00);

        // Tie after reset: req0 first, req1 in next IDLE
        do_reset();
        drive(0, 1'b1, 8'h55, 8'h1a, 3'b000);
        drive(1, 1'b1, 8'h55, 8'h1a, 3'b001);
        @(negedge clk);
        check("tie_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 1);
        tick();
        drive(0, 1'b0, 8'h55, 8'h1a, 3'b000);
        @(negedge clk);
        check("tie_no_ready_exec", bus.req1_ready, 0);
        @(negedge clk);
        check("tie_no_ready_resp", bus.req1_ready, 0);
        check("tie_resp0", bus.resp0_data, 8'h6f);
        @(negedge clk);
        check("tie_req1_ready", bus.req1_ready, 1);
        tick();
        drive(1, 1'b0, 8'h55, 8'h1a, 3'b001);
        repeat (2) @(negedge clk);
        check("tie_resp1_valid", bus.resp1_valid, 1);
        check("tie_resp1_data", bus.resp1_data, 8'h3b);

        // Fairness with both held valid
        do_reset();
        grants.delete();
        drive(0, 1'b1, 8'h10, 8'h20, 3'b000);
        drive(1, 1'b1, 8'h50, 8'h10, 3'b001);
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        tick();
        drive(0, 1'b0, 8'h10, 8'h20, 3'b000);
        drive(1, 1'b0, 8'h50, 8'h10, 3'b001);
        repeat (4) tick();
        check("fair_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check($sformatf("fair_grant%0d", i), grants[i], 0);
`else
            check($sformatf("fair_grant%0d", i), grants[i], i % 2);
`endif
        end

        // Reset during EXEC aborts the operation
        do_reset();
        drive(0, 1'b1, 8'h11, 8'h22, 3'b000);
        @(negedge clk);
        check("abort_accept", bus.req0_ready, 1);
        tick();
        drive(0, 1'b0, 8'h11, 8'h22, 3'b000);
        rst = 1'b1;
        tick();
        drive(1, 1'b1, 8'h55, 8'h1a, 3'b001);
        @(negedge clk);
        check("abort_resp", {30'd0, bus.resp1_valid, bus.resp0_valid}, 0);
        check("abort_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        check("abort_data", {bus.resp1_data, bus.resp0_data}, 0);
        check("abort_alu", {bus.alu_c, bus.alu_src_a, bus.alu_src_b}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_fresh_ready", bus.req1_ready, 1);
        tick();
        drive(1, 1'b0, 8'h55, 8'h1a, 3'b001);
        repeat (2) @(negedge clk);
        check("abort_fresh_resp", bus.resp1_valid, 1);
        check("abort_fresh_data", bus.resp1_data, 8'h3b);
        check("abort_no_resp0", bus.resp0_valid, 0);

        repeat (3) tick();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
